// File: rtl/ternary_pkg.sv
// ternary_pkg
// Shared definitions for the ternary weight unpacker:
//   - 2-bit trit encoding (0, +1, -1)
//   - byte-packing constants (5 trits per byte, codes >= 243 are commands)
//   - trit buffer geometry and FSM state type
//   - helpers turning a trit into {zero, sign} flags and picking a trit
//     out of a decoded byte
package ternary_pkg;

  localparam logic [1:0] TRIT_ZERO = 2'd0;
  localparam logic [1:0] TRIT_POS  = 2'd1;
  localparam logic [1:0] TRIT_NEG  = 2'd2;

  localparam int         TRITS_PER_BYTE      = 5;
  localparam logic [7:0] CODE_LIMIT          = 8'd243;
  localparam logic [7:0] CMD_READOUT_DEFAULT = 8'hFF;

  localparam int FIFO_DEPTH = 8;
  localparam int COUNT_W    = 4;

  typedef enum logic [1:0] {
    RUN,
    FLUSH,
    STROBE
  } state_t;

  // Returns {zero, sign}. The unused encoding 2'd3 is treated as zero.
  function automatic logic [1:0] trit_to_zero_sign(input logic [1:0] trit);
    case (trit)
      TRIT_POS: return 2'b00;
      TRIT_NEG: return 2'b01;
      default:  return 2'b10;
    endcase
  endfunction

  // Picks trit k (0 = least significant) from a packed decoded byte.
  function automatic logic [1:0] trit_select(input logic [2*TRITS_PER_BYTE-1:0] trits,
                                             input logic [2:0] k);
    case (k)
      3'd0:    return trits[1:0];
      3'd1:    return trits[3:2];
      3'd2:    return trits[5:4];
      3'd3:    return trits[7:6];
      3'd4:    return trits[9:8];
      default: return TRIT_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/ternary_byte_decode.sv
// ternary_byte_decode
// Combinational base-3 decoder: splits a byte v < 243 into five trits,
// v = t0 + 3*t1 + 9*t2 + 27*t3 + 81*t4, and flags command codes (>= 243).
// Ports:
//   code   - input byte
//   trits  - packed trits, t_k in bits [2k+1:2k]
//   is_cmd - code is in the reserved command range
module ternary_byte_decode
  import ternary_pkg::*;
(
  input  logic [7:0]                  code,
  output logic [2*TRITS_PER_BYTE-1:0] trits,
  output logic                        is_cmd
);

  logic [7:0] rest;

  always_comb begin
    rest  = code;
    trits = '0;
    for (int k = 0; k < TRITS_PER_BYTE; k++) begin
      trits[2*k +: 2] = 2'(rest % 8'd3);
      rest            = rest / 8'd3;
    end
  end

  assign is_cmd = (code >= CODE_LIMIT);

endmodule

// File: rtl/ternary_weight_unpacker.sv
// ternary_weight_unpacker
// Re-gears a byte stream of base-3 packed ternary weights (5 trits/byte)
// into beats of LANES zero/sign flags, and turns the CMD_READOUT code into
// a flush of pending trits followed by a one-cycle readout strobe.
// Ports:
//   clk, reset           - clock, synchronous active-high reset
//   in_byte/in_valid/in_ready - packed weight or command input (valid/ready)
//   out_zero/out_sign/out_valid/out_ready - beat output, lane 0 = oldest trit
//   readout              - one-cycle pulse after a readout flush completes
//   busy                 - trits buffered or not in RUN
module ternary_weight_unpacker
  import ternary_pkg::*;
#(
  parameter int         LANES       = 4,
  parameter logic [7:0] CMD_READOUT = CMD_READOUT_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       in_byte,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [LANES-1:0] out_zero,
  output logic [LANES-1:0] out_sign,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             readout,
  output logic             busy
);

  localparam logic [COUNT_W-1:0] LANES_C    = COUNT_W'(LANES);
  localparam logic [COUNT_W-1:0] BYTE_C     = COUNT_W'(TRITS_PER_BYTE);
  // A byte fits only if at most this many trits remain after any pop.
  localparam logic [COUNT_W-1:0] ROOM_LIMIT = COUNT_W'(FIFO_DEPTH - TRITS_PER_BYTE);

  // Trit buffer: slot 0 holds the oldest trit.
  logic [2*FIFO_DEPTH-1:0] fifo_reg, fifo_next;
  logic [COUNT_W-1:0]      count_reg, count_next, count_after_pop;
  state_t                  state_reg, state_next;
  logic                    out_valid_reg, out_valid_next;
  logic [LANES-1:0]        out_zero_reg, out_zero_next;
  logic [LANES-1:0]        out_sign_reg, out_sign_next;
  logic                    readout_reg;

  logic [2*TRITS_PER_BYTE-1:0] dec_trits;
  logic                        dec_is_cmd;
  logic                        emit, pop_full, accept, push, readout_cmd;

  ternary_byte_decode u_decode (
    .code   (in_byte),
    .trits  (dec_trits),
    .is_cmd (dec_is_cmd)
  );

  assign emit     = out_valid_reg && out_ready;
  assign pop_full = emit && (count_reg >= LANES_C);

  // A partial beat can only be emitted while flushing and empties the buffer.
  always_comb begin
    count_after_pop = count_reg;
    if (pop_full) begin
      count_after_pop = count_reg - LANES_C;
    end else if (emit) begin
      count_after_pop = '0;
    end
  end

  assign in_ready    = (state_reg == RUN) && (count_after_pop <= ROOM_LIMIT);
  assign accept      = in_valid && in_ready;
  assign push        = accept && !dec_is_cmd;
  assign readout_cmd = accept && dec_is_cmd && (in_byte == CMD_READOUT);
  assign count_next  = count_after_pop + (push ? BYTE_C : '0);

  // Next state. The readout command checks the post-pop count so a beat
  // emitted in the same cycle that empties the buffer goes straight to STROBE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN: begin
        if (readout_cmd) begin
          state_next = (count_after_pop == '0) ? STROBE : FLUSH;
        end
      end
      FLUSH: begin
        if (emit && (count_after_pop == '0)) begin
          state_next = STROBE;
        end
      end
      STROBE:  state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // Per slot: take a newly decoded trit if the slot lies in the write window
  // just above the surviving trits, else shift down by one beat on a pop.
  for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_slot
    logic [1:0]         shifted;
    logic [COUNT_W-1:0] offset;

    if (gi + LANES < FIFO_DEPTH) begin : g_src
      assign shifted = fifo_reg[2*(gi+LANES) +: 2];
    end else begin : g_pad
      assign shifted = TRIT_ZERO;
    end

    // Wraps to a large value for slots below the write window.
    assign offset = COUNT_W'(gi) - count_after_pop;

    assign fifo_next[2*gi +: 2] = (push && (offset < BYTE_C)) ? trit_select(dec_trits, offset[2:0])
                                : pop_full                    ? shifted
                                :                               fifo_reg[2*gi +: 2];
  end

  // Output beat is computed from next-cycle buffer contents and registered;
  // lanes beyond the live count are padded with zero trits.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [1:0] lane_trit;
    assign lane_trit = (COUNT_W'(gi) < count_next) ? fifo_next[2*gi +: 2] : TRIT_ZERO;
    assign {out_zero_next[gi], out_sign_next[gi]} = trit_to_zero_sign(lane_trit);
  end

  assign out_valid_next = (count_next >= LANES_C) ||
                          ((state_next == FLUSH) && (count_next != '0));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= RUN;
      count_reg     <= '0;
      out_valid_reg <= 1'b0;
      out_zero_reg  <= '1;
      out_sign_reg  <= '0;
      readout_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      out_valid_reg <= out_valid_next;
      out_zero_reg  <= out_zero_next;
      out_sign_reg  <= out_sign_next;
      readout_reg   <= (state_next == STROBE);
    end
  end

  // Contents beyond count are don't-care, so the buffer needs no reset.
  always_ff @(posedge clk) begin
    fifo_reg <= fifo_next;
  end

  assign out_valid = out_valid_reg;
  assign out_zero  = out_zero_reg;
  assign out_sign  = out_sign_reg;
  assign readout   = readout_reg;
  assign busy      = (count_reg != '0) || (state_reg != RUN);

endmodule

// File: tb/tb_ternary_weight_unpacker.sv
// tb_ternary_weight_unpacker
// Randomized and directed stimulus checked every cycle against a
// queue-based behavioural model of the unpacker.
module tb_ternary_weight_unpacker;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in_byte = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] out_zero, out_sign;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       readout;
  logic       busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ternary_weight_unpacker dut (
    .clk       (clk),
    .reset     (reset),
    .in_byte   (in_byte),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_zero  (out_zero),
    .out_sign  (out_sign),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .readout   (readout),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_q: pending trits (0, 1=+1, 2=-1), front = oldest
  // m_mode: 0 run, 1 flushing, 2 readout pulse cycle
  int   m_q[$];
  int   m_mode = 0;
  bit   m_after_reset = 1'b0;
  int   sz, popn, after_pop;
  bit   exp_valid, exp_ready, emit;
  logic [3:0] ez, es;

  function automatic int trit_of(input int v, input int k);
    int p = 1;
    for (int i = 0; i < k; i++) p = p * 3;
    return (v / p) % 3;
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      m_q.delete();
      m_mode = 0;
      m_after_reset = 1'b1;
    end else begin
      sz = m_q.size();
      exp_valid = (sz >= 4) || (m_mode == 1 && sz > 0);
      check("out_valid", 32'(out_valid), 32'(exp_valid));
      for (int i = 0; i < 4; i++) begin
        int t;
        t = (i < sz) ? m_q[i] : 0;
        ez[i] = (t == 0);
        es[i] = (t == 2);
      end
      if (exp_valid) begin
        check("out_zero", 32'(out_zero), 32'(ez));
        check("out_sign", 32'(out_sign), 32'(es));
      end
      if (m_after_reset) begin
        check("rst_zero", 32'(out_zero), 32'hF);
        check("rst_sign", 32'(out_sign), 32'h0);
        m_after_reset = 1'b0;
      end
      check("readout", 32'(readout), 32'(m_mode == 2));
      check("busy", 32'(busy), 32'((sz != 0) || (m_mode != 0)));

      emit = exp_valid && out_ready;
      popn = emit ? ((sz < 4) ? sz : 4) : 0;
      after_pop = sz - popn;
      exp_ready = (m_mode == 0) && (after_pop + 5 <= 8);
      check("in_ready", 32'(in_ready), 32'(exp_ready));

      if (emit) begin
        $display("beat zero=%b sign=%b", ez, es);
        for (int i = 0; i < popn; i++) void'(m_q.pop_front());
      end

      if (m_mode == 2) begin
        $display("readout pulse");
        m_mode = 0;
      end else if (m_mode == 1) begin
        if (emit && m_q.size() == 0) m_mode = 2;
      end else if (in_valid && exp_ready) begin
        if (int'(in_byte) < 243) begin
          for (int k = 0; k < 5; k++) m_q.push_back(trit_of(int'(in_byte), k));
          $display("byte %02h accepted", in_byte);
        end else if (in_byte == 8'hFF) begin
          m_mode = (m_q.size() == 0) ? 2 : 1;
          $display("readout command accepted");
        end else begin
          $display("reserved code %02h dropped", in_byte);
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit done;
    done = 1'b0;
    in_byte  = b;
    in_valid = 1'b1;
    for (int n = 0; n < 64 && !done; n++) begin
      @(negedge clk);
      done = in_ready;
      tick();
    end
    in_valid = 1'b0;
    if (!done) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_not_busy(input int limit);
    int n;
    n = 0;
    while (busy && n < limit) begin
      tick();
      n++;
    end
    if (busy) check("drain_timeout", 32'd0, 32'd1);
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    out_ready = 1'b1;

    // all-zero byte, then flush the leftover trit
    send_byte(8'h00);
    repeat (4) tick();
    send_byte(8'hFF);
    wait_not_busy(40);

    // single mixed byte, idle, then readout flush of the held trit
    send_byte(8'hC4);
    repeat (5) tick();
    send_byte(8'hFF);
    wait_not_busy(40);

    // continuous all-negative stream
    for (int i = 0; i < 5; i++) send_byte(8'hF2);
    repeat (4) tick();
    send_byte(8'hFF);
    wait_not_busy(40);

    // backpressure with buffer filling to 8, then a reserved code
    for (int i = 0; i < 3; i++) send_byte(8'hF2);
    repeat (2) tick();
    fork
      begin
        send_byte(8'hC4);
        send_byte(8'h79);
      end
      begin
        out_ready = 1'b0;
        repeat (10) tick();
        out_ready = 1'b1;
      end
    join
    repeat (6) tick();
    send_byte(8'hF3);
    repeat (4) tick();
    send_byte(8'hFF);
    wait_not_busy(40);

    // reset in the middle of a stalled flush
    send_byte(8'hC4);
    tick();
    out_ready = 1'b0;
    send_byte(8'hFF);
    repeat (2) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    out_ready = 1'b1;
    send_byte(8'h00);
    repeat (3) tick();
    send_byte(8'hFF);
    wait_not_busy(40);

    // random traffic, in_valid not held
    for (int c = 0; c < 600; c++) begin
      int r;
      r = int'($urandom_range(0, 19));
      if (r == 0)      in_byte = 8'hFF;
      else if (r == 1) in_byte = 8'(243 + $urandom_range(0, 11));
      else             in_byte = 8'($urandom_range(0, 242));
      in_valid  = ($urandom_range(0, 9) < 6);
      out_ready = ($urandom_range(0, 9) < 7);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (20) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
